trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Sequences the machine-mode CSR file (single read/write port) for trap entry and mret.
//  Muxes the core's CSR-instruction access with its own multi-cycle write sequences.
//  On exception, external interrupt or mret, it updates mepc/mcause/mstatus one CSR per cycle.
//  It then issues a PC redirect to the fetch stage. Sits between decode/execute and csr_file.
// PARAMETERS
//  VECTORED_EN  1   1: honour mtvec[1:0]==01 vectored mode for interrupts; 0: always direct
//  IRQ_CAUSE    11  interrupt code written to mcause[30:0] (machine external interrupt)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-low
//  core_csr_valid in   1   core CSR-instruction access this cycle
//  core_csr_we    in   1   core access is a write
//  core_csr_addr  in   12  core CSR address
//  core_csr_wdata in   32  core write data
//  core_csr_rdata out  32  read data returned to core (= csr_rdata)
//  trap_req       in   1   synchronous exception; held until trap_ack
//  trap_cause     in   31  exception code (mcause[30:0])
//  trap_pc        in   32  PC of faulting instruction
//  mret_req       in   1   mret retiring; held until mret_ack
//  irq_ext        in   1   external interrupt line, level
//  irq_pc         in   32  PC of next unexecuted instruction (mepc for interrupts)
//  trap_ack       out  1   1-cycle pulse: trap_req or interrupt accepted
//  mret_ack       out  1   1-cycle pulse: mret_req accepted
//  busy           out  1   sequence in progress; core must stall
//  redirect_valid out  1   1-cycle pulse: fetch must jump to redirect_pc
//  redirect_pc    out  32  target PC
//  csr_write_en   out  1   to csr_file write_en
//  csr_addr       out  12  to csr_file addr
//  csr_wdata      out  32  to csr_file in
//  csr_rdata      in   32  from csr_file out (combinational)
//  mstatus        in   32  from csr_file mstatus
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, meie_q=0, all latches 0.
//   All outputs 0 except csr_addr/csr_wdata, which follow core_csr_* as in IDLE.
//  CSR addrs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342.
//  mstatus bits: MIE[3], MPIE[7], MPP[12:11].
//  meie_q shadows mie[11]: updated when IDLE && core_csr_valid && core_csr_we && addr==0x304.
//  IDLE: csr_addr/csr_wdata follow core_csr_*; csr_write_en = core_csr_valid & core_csr_we.
//   Request priority, evaluated every IDLE cycle:
//   1. trap_req.
//   2. mret_req.
//   3. Interrupt: irq_ext & mstatus[3] & meie_q.
//   Accepting a request: pulse trap_ack/mret_ack, suppress this cycle's core write,
//    latch pc (trap_pc or irq_pc), cause {is_irq, code}, is_irq; go to W_EPC or M_STATUS.
//  Trap sequence, busy=1, accept at cycle T:
//   T+1 W_EPC: write mepc = {pc[31:2],2'b00}.
//   T+2 W_CAUSE: write mcause = {is_irq, code}.
//   T+3 W_STATUS: write mstatus = mstatus with MPIE=MIE, MIE=0, MPP=2'b11.
//   T+4 VECTOR: csr_addr=0x305, no write.
//    redirect_pc = {rdata[31:2],2'b00} + ((VECTORED_EN & rdata[1:0]==01 & is_irq) ? 4*code : 0).
//    redirect_valid=1, 32-bit wrap-around add; then IDLE.
//  Mret sequence, accept at cycle T:
//   T+1 M_STATUS: write mstatus with MIE=MPIE, MPIE=1, MPP kept.
//   T+2 M_EPC: csr_addr=0x341, no write; redirect_pc = {rdata[31:2],2'b00}; redirect_valid=1; then IDLE.
//  Non-IDLE: core_csr_* ignored (no writes, meie_q frozen); requests not accepted.
//   Requests stay pending while busy.
//  busy=1 in every non-IDLE state.
//  Interrupt is re-evaluated only in IDLE, so W_STATUS clearing MIE masks re-entry.
//  Reset mid-sequence: immediate IDLE, no redirect. CSR contents already written remain.
// TESTING
//  1. Reset values: rst low -> busy=0, redirect_valid=0, trap_ack=0, csr_write_en=0.
//  2. Exception: mstatus=0x8, trap_req, cause=2, pc=0x104, mtvec=0x200.
//   -> mepc=0x104, mcause=0x2, mstatus=0x1880, redirect_pc=0x200 at T+4.
//  3. Vectored IRQ: mie=0x800, mstatus=0x8, mtvec=0x201, irq_ext.
//   -> mcause=0x8000000B, redirect_pc=0x22C, and no re-entry while irq_ext is held.
//  4. Mret: mstatus=0x1880, mepc=0x104 -> mstatus=0x1888, redirect_pc=0x104 at T+2.
//  5. Priority: trap_req, mret_req and irq all asserted in IDLE -> trap_ack first.
//   Core write issued while busy has no effect.
//  6. Reset asserted at W_CAUSE -> IDLE next edge, no redirect, mepc already updated.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - core, csr_file and fetch-facing signals of the trap sequencer
interface trap_ctrl_if;
  logic        core_csr_valid;
  logic        core_csr_we;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic [31:0] core_csr_rdata;
  logic        trap_req;
  logic [30:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret_req;
  logic        irq_ext;
  logic [31:0] irq_pc;
  logic        trap_ack;
  logic        mret_ack;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_write_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mstatus;

  // master: core pipeline plus csr_file; slave: the trap sequencer
  modport master (
    output core_csr_valid, core_csr_we, core_csr_addr, core_csr_wdata,
    output trap_req, trap_cause, trap_pc, mret_req, irq_ext, irq_pc,
    output csr_rdata, mstatus,
    input  core_csr_rdata, trap_ack, mret_ack, busy, redirect_valid, redirect_pc,
    input  csr_write_en, csr_addr, csr_wdata
  );

  modport slave (
    input  core_csr_valid, core_csr_we, core_csr_addr, core_csr_wdata,
    input  trap_req, trap_cause, trap_pc, mret_req, irq_ext, irq_pc,
    input  csr_rdata, mstatus,
    output core_csr_rdata, trap_ack, mret_ack, busy, redirect_valid, redirect_pc,
    output csr_write_en, csr_addr, csr_wdata
  );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer in front of a single-port CSR file
module trap_ctrl #(
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [30:0] IRQ_CAUSE   = 31'd11
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_STATUS, VECTOR, M_STATUS, M_EPC
  } state_t;

  state_t      state_q, state_d;
  logic        meie_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;

  logic        core_wr;
  logic        irq_pending;
  logic        take_trap, take_mret, take_irq;
  logic        trap_ack, mret_ack, redirect_valid, csr_write_en;
  logic [31:0] redirect_pc, csr_wdata, vec_off;
  logic [11:0] csr_addr;
  logic [31:0] status_trap, status_mret;

  assign core_wr     = bus.core_csr_valid & bus.core_csr_we;
  assign irq_pending = bus.irq_ext & bus.mstatus[3] & meie_q;

  always_comb begin
    status_trap        = bus.mstatus;
    status_trap[7]     = bus.mstatus[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret        = bus.mstatus;
    status_mret[3]     = bus.mstatus[7];
    status_mret[7]     = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    take_trap      = 1'b0;
    take_mret      = 1'b0;
    take_irq       = 1'b0;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    vec_off        = 32'h0;
    csr_write_en   = 1'b0;
    csr_addr       = bus.core_csr_addr;
    csr_wdata      = bus.core_csr_wdata;

    unique case (state_q)
      IDLE: begin
        csr_write_en = core_wr;
        // accepting any request steals this cycle's CSR port from the core
        if (bus.trap_req) begin
          take_trap    = 1'b1;
          trap_ack     = 1'b1;
          csr_write_en = 1'b0;
          state_d      = W_EPC;
        end else if (bus.mret_req) begin
          take_mret    = 1'b1;
          mret_ack     = 1'b1;
          csr_write_en = 1'b0;
          state_d      = M_STATUS;
        end else if (irq_pending) begin
          take_irq     = 1'b1;
          trap_ack     = 1'b1;
          csr_write_en = 1'b0;
          state_d      = W_EPC;
        end
      end
      W_EPC: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MEPC;
        csr_wdata    = pc_q & ~32'h3;
        state_d      = W_CAUSE;
      end
      W_CAUSE: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MCAUSE;
        csr_wdata    = cause_q;
        state_d      = W_STATUS;
      end
      W_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = status_trap;
        state_d      = VECTOR;
      end
      VECTOR: begin
        csr_addr  = ADDR_MTVEC;
        csr_wdata = 32'h0;
        // vectored mode applies to interrupts only; exceptions always use the base
        if (VECTORED_EN && cause_q[31] && (bus.csr_rdata[1:0] == 2'b01))
          vec_off = {cause_q[29:0], 2'b00};
        redirect_pc    = (bus.csr_rdata & ~32'h3) + vec_off;
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      M_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = status_mret;
        state_d      = M_EPC;
      end
      M_EPC: begin
        csr_addr       = ADDR_MEPC;
        csr_wdata      = 32'h0;
        redirect_pc    = bus.csr_rdata & ~32'h3;
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // while reset is held the IDLE pass-through must not reach the CSR file
    if (!rst) begin
      trap_ack       = 1'b0;
      mret_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      csr_write_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      meie_q  <= 1'b0;
      pc_q    <= 32'h0;
      cause_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        pc_q    <= bus.trap_pc;
        cause_q <= {1'b0, bus.trap_cause};
      end else if (take_irq) begin
        pc_q    <= bus.irq_pc;
        cause_q <= {1'b1, IRQ_CAUSE};
      end
      // shadow tracks only mie writes that actually reach the CSR file
      if ((state_q == IDLE) && core_wr && (bus.core_csr_addr == ADDR_MIE) &&
          !(take_trap | take_mret | take_irq))
        meie_q <= bus.core_csr_wdata[11];
    end
  end

  assign bus.core_csr_rdata = bus.csr_rdata;
  assign bus.trap_ack       = trap_ack;
  assign bus.mret_ack       = mret_ack;
  assign bus.busy           = (state_q != IDLE);
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.csr_write_en   = csr_write_en;
  assign bus.csr_addr       = csr_addr;
  assign bus.csr_wdata      = csr_wdata;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed bench for trap_ctrl with a behavioural csr_file
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if bus();

  trap_ctrl #(.VECTORED_EN(1'b1), .IRQ_CAUSE(31'd11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [31:0] m_status = 32'h0;
  logic [31:0] m_ie     = 32'h0;
  logic [31:0] m_tvec   = 32'h0;
  logic [31:0] m_epc    = 32'h0;
  logic [31:0] m_cause  = 32'h0;
  logic [31:0] rd_mux;

  always @(posedge clk) begin
    if (bus.csr_write_en) begin
      case (bus.csr_addr)
        12'h300: m_status <= bus.csr_wdata;
        12'h304: m_ie     <= bus.csr_wdata;
        12'h305: m_tvec   <= bus.csr_wdata;
        12'h341: m_epc    <= bus.csr_wdata;
        12'h342: m_cause  <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (bus.csr_addr)
      12'h300: rd_mux = m_status;
      12'h304: rd_mux = m_ie;
      12'h305: rd_mux = m_tvec;
      12'h341: rd_mux = m_epc;
      12'h342: rd_mux = m_cause;
      default: rd_mux = 32'h0;
    endcase
  end

  assign bus.csr_rdata = rd_mux;
  assign bus.mstatus   = m_status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        valid;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        irq;
    logic        exp_we;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    bus.core_csr_valid = 1'b0;
    bus.core_csr_we    = 1'b0;
    bus.core_csr_addr  = 12'h0;
    bus.core_csr_wdata = 32'h0;
  endtask

  task automatic core_wr(input logic [11:0] addr, input logic [31:0] data);
    bus.core_csr_valid = 1'b1;
    bus.core_csr_we    = 1'b1;
    bus.core_csr_addr  = addr;
    bus.core_csr_wdata = data;
    next();
    clear_core();
  endtask

  task automatic run_trap(input string n, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] status, input logic [31:0] tgt);
    @(negedge clk);
    chk({n, "_epc_we"}, 32'(bus.csr_write_en), 32'h1);
    chk({n, "_epc_addr"}, 32'(bus.csr_addr), 32'h341);
    chk({n, "_epc_data"}, bus.csr_wdata, epc);
    chk({n, "_busy"}, 32'(bus.busy), 32'h1);
    chk({n, "_no_ack_busy"}, 32'(bus.trap_ack | bus.mret_ack), 32'h0);
    next();
    @(negedge clk);
    chk({n, "_cause_addr"}, 32'(bus.csr_addr), 32'h342);
    chk({n, "_cause_data"}, bus.csr_wdata, cause);
    next();
    @(negedge clk);
    chk({n, "_status_addr"}, 32'(bus.csr_addr), 32'h300);
    chk({n, "_status_data"}, bus.csr_wdata, status);
    next();
    clear_core();
    @(negedge clk);
    chk({n, "_vec_we"}, 32'(bus.csr_write_en), 32'h0);
    chk({n, "_redir_valid"}, 32'(bus.redirect_valid), 32'h1);
    chk({n, "_redir_pc"}, bus.redirect_pc, tgt);
    next();
    @(negedge clk);
    chk({n, "_idle"}, 32'(bus.busy), 32'h0);
    chk({n, "_redir_drop"}, 32'(bus.redirect_valid), 32'h0);
    chk({n, "_mepc"}, m_epc, epc);
    chk({n, "_mcause"}, m_cause, cause);
    chk({n, "_mstatus"}, m_status, status);
  endtask

  task automatic run_mret(input string n, input logic [31:0] status, input logic [31:0] tgt);
    @(negedge clk);
    chk({n, "_st_we"}, 32'(bus.csr_write_en), 32'h1);
    chk({n, "_st_addr"}, 32'(bus.csr_addr), 32'h300);
    chk({n, "_st_data"}, bus.csr_wdata, status);
    chk({n, "_busy"}, 32'(bus.busy), 32'h1);
    next();
    @(negedge clk);
    chk({n, "_epc_we"}, 32'(bus.csr_write_en), 32'h0);
    chk({n, "_redir_valid"}, 32'(bus.redirect_valid), 32'h1);
    chk({n, "_redir_pc"}, bus.redirect_pc, tgt);
    next();
    @(negedge clk);
    chk({n, "_idle"}, 32'(bus.busy), 32'h0);
    chk({n, "_mstatus"}, m_status, status);
  endtask

  initial begin
    vecs[0] = '{"wr_mtvec",    1'b1, 1'b1, 12'h305, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{"wr_mstatus",  1'b1, 1'b1, 12'h300, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{"rd_mtvec",    1'b1, 1'b0, 12'h305, 32'h0,         1'b0, 1'b0, 1'b1, 32'h200};
    vecs[3] = '{"invalid_we",  1'b0, 1'b1, 12'h305, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{"irq_no_meie", 1'b0, 1'b0, 12'h000, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"rd_mstatus",  1'b1, 1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8};

    // reset held with every request and a core write asserted
    bus.core_csr_valid = 1'b1;
    bus.core_csr_we    = 1'b1;
    bus.core_csr_addr  = 12'h305;
    bus.core_csr_wdata = 32'hFFFF_FFFF;
    bus.trap_req       = 1'b1;
    bus.trap_cause     = 31'h0;
    bus.trap_pc        = 32'h0;
    bus.mret_req       = 1'b1;
    bus.irq_ext        = 1'b1;
    bus.irq_pc         = 32'h0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_redir", 32'(bus.redirect_valid), 32'h0);
    chk("rst_trap_ack", 32'(bus.trap_ack), 32'h0);
    chk("rst_mret_ack", 32'(bus.mret_ack), 32'h0);
    chk("rst_csr_we", 32'(bus.csr_write_en), 32'h0);
    chk("rst_addr_follow", 32'(bus.csr_addr), 32'h305);
    chk("rst_no_write", m_tvec, 32'h0);
    clear_core();
    bus.trap_req = 1'b0;
    bus.mret_req = 1'b0;
    bus.irq_ext  = 1'b0;
    next();
    rst = 1'b1;
    next();

    for (int i = 0; i < 6; i++) begin
      bus.core_csr_valid = vecs[i].valid;
      bus.core_csr_we    = vecs[i].we;
      bus.core_csr_addr  = vecs[i].addr;
      bus.core_csr_wdata = vecs[i].wdata;
      bus.irq_ext        = vecs[i].irq;
      @(negedge clk);
      chk({vecs[i].name, "_we"}, 32'(bus.csr_write_en), 32'(vecs[i].exp_we));
      chk({vecs[i].name, "_addr"}, 32'(bus.csr_addr), 32'(vecs[i].addr));
      chk({vecs[i].name, "_ack"}, 32'(bus.trap_ack), 32'h0);
      chk({vecs[i].name, "_busy"}, 32'(bus.busy), 32'h0);
      if (vecs[i].chk_rd)
        chk({vecs[i].name, "_rdata"}, bus.core_csr_rdata, vecs[i].exp_rd);
      next();
    end
    clear_core();
    bus.irq_ext = 1'b0;

    // synchronous exception, direct mtvec
    bus.trap_req   = 1'b1;
    bus.trap_cause = 31'd2;
    bus.trap_pc    = 32'h104;
    @(negedge clk);
    chk("exc_ack", 32'(bus.trap_ack), 32'h1);
    next();
    bus.trap_req = 1'b0;
    run_trap("exc", 32'h104, 32'h2, 32'h1880, 32'h200);
    next();

    // vectored external interrupt, held after entry
    core_wr(12'h304, 32'h800);
    core_wr(12'h300, 32'h8);
    core_wr(12'h305, 32'h201);
    bus.irq_ext = 1'b1;
    bus.irq_pc  = 32'h302;
    @(negedge clk);
    chk("irq_ack", 32'(bus.trap_ack), 32'h1);
    next();
    run_trap("irq", 32'h300, 32'h8000_000B, 32'h1880, 32'h22C);
    chk("irq_no_reentry0", 32'(bus.trap_ack), 32'h0);
    next();
    @(negedge clk);
    chk("irq_no_reentry1", 32'(bus.trap_ack), 32'h0);
    chk("irq_no_reentry_busy", 32'(bus.busy), 32'h0);
    next();
    bus.irq_ext = 1'b0;

    // mret
    core_wr(12'h341, 32'h104);
    bus.mret_req = 1'b1;
    @(negedge clk);
    chk("mret_ack", 32'(bus.mret_ack), 32'h1);
    chk("mret_no_trap_ack", 32'(bus.trap_ack), 32'h0);
    chk("mret_accept_we", 32'(bus.csr_write_en), 32'h0);
    next();
    bus.mret_req = 1'b0;
    run_mret("mret", 32'h1888, 32'h104);
    next();

    // priority: all three requests together, plus a core write into mtvec held through busy
    bus.trap_req       = 1'b1;
    bus.trap_cause     = 31'd5;
    bus.trap_pc        = 32'h402;
    bus.mret_req       = 1'b1;
    bus.irq_ext        = 1'b1;
    bus.core_csr_valid = 1'b1;
    bus.core_csr_we    = 1'b1;
    bus.core_csr_addr  = 12'h305;
    bus.core_csr_wdata = 32'hDEAD;
    @(negedge clk);
    chk("prio_trap_ack", 32'(bus.trap_ack), 32'h1);
    chk("prio_mret_wait", 32'(bus.mret_ack), 32'h0);
    chk("prio_core_suppressed", 32'(bus.csr_write_en), 32'h0);
    next();
    bus.trap_req = 1'b0;
    bus.irq_ext  = 1'b0;
    run_trap("prio", 32'h400, 32'h5, 32'h1880, 32'h200);
    chk("prio_mret_after", 32'(bus.mret_ack), 32'h1);
    chk("prio_mtvec_kept", m_tvec, 32'h201);
    next();
    bus.mret_req = 1'b0;
    run_mret("prio_mret", 32'h1888, 32'h400);
    next();

    // reset asserted during W_CAUSE
    bus.trap_req   = 1'b1;
    bus.trap_cause = 31'd7;
    bus.trap_pc    = 32'h500;
    @(negedge clk);
    chk("rstmid_ack", 32'(bus.trap_ack), 32'h1);
    next();
    bus.trap_req = 1'b0;
    @(negedge clk);
    chk("rstmid_epc_addr", 32'(bus.csr_addr), 32'h341);
    next();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(bus.busy), 32'h0);
    chk("rstmid_we", 32'(bus.csr_write_en), 32'h0);
    chk("rstmid_redir", 32'(bus.redirect_valid), 32'h0);
    chk("rstmid_mepc", m_epc, 32'h500);
    chk("rstmid_mcause", m_cause, 32'h5);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_idle", 32'(bus.busy), 32'h0);
    chk("rstmid_redir1", 32'(bus.redirect_valid), 32'h0);
    next();
    @(negedge clk);
    chk("rstmid_redir2", 32'(bus.redirect_valid), 32'h0);
    chk("rstmid_mcause_kept", m_cause, 32'h5);
    chk("rstmid_mstatus_kept", m_status, 32'h1888);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
